// File: rtl/psum_pkg.sv
// Shared types for the psum bank manager: bank indices, op descriptors and sequencer states.
package psum_pkg;

   localparam int unsigned NUM_BANKS   = 8;
   localparam int unsigned NUM_SMALL   = 4;
   localparam int unsigned SMALL_DEPTH = 16;
   localparam int unsigned BANK_W      = 3;
   localparam int unsigned SEQ2_W      = 16;
   // Descriptor fields are sized for the widest supported configuration.
   localparam int unsigned DESC_ADDR_W = 16;
   localparam int unsigned DESC_ID_W   = 16;

   typedef logic [BANK_W-1:0] bank_idx_t;

   typedef struct packed {
      bank_idx_t              bank;
      logic [DESC_ADDR_W-1:0] seq1;
      logic [SEQ2_W-1:0]      seq2;
      logic [DESC_ID_W-1:0]   id;
   } op_desc_t;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_t;

   // Lowest-index free bank within the small (0-3) or big (4-7) class.
   function automatic bank_idx_t pick_bank(input logic [NUM_BANKS-1:0] busy, input logic big);
      bank_idx_t base;
      logic      found;
      base      = big ? BANK_W'(NUM_SMALL) : '0;
      pick_bank = base;
      found     = 1'b0;
      for (int i = 0; i < int'(NUM_SMALL); i++) begin
         if (!found && !busy[base + BANK_W'(i)]) begin
            pick_bank = base + BANK_W'(i);
            found     = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/psum_addr_seq.sv
// Nested a/p address sequencer for one active psum operation, with one-cycle DONE reporting.
module psum_addr_seq
   import psum_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned OP_ID_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  bank_idx_t              load_bank,
   input  logic [ADDR_WIDTH-1:0]  load_seq1,
   input  logic [SEQ2_W-1:0]      load_seq2,
   input  logic [OP_ID_WIDTH-1:0] load_id,
   output seq_state_t             state,
   output bank_idx_t              active_bank,
   output logic [2:0]             read_bank_index,
   output logic [ADDR_WIDTH-1:0]  read_address,
   output logic [ADDR_WIDTH-1:0]  write_address,
   output logic                   op_done,
   output logic [OP_ID_WIDTH-1:0] op_done_id
);

   logic [ADDR_WIDTH-1:0]  seq1_q;
   logic [SEQ2_W-1:0]      seq2_q;
   logic [SEQ2_W-1:0]      pass_q;
   logic [OP_ID_WIDTH-1:0] id_q;
   logic                   load_zero_c;
   logic                   last_addr_c;
   logic                   last_pass_c;

   assign load_zero_c = (load_seq1 == '0) || (load_seq2 == '0);
   assign last_addr_c = (read_address == seq1_q - ADDR_WIDTH'(1));
   assign last_pass_c = (pass_q == seq2_q - SEQ2_W'(1));

   // read_address doubles as the inner counter; write_address trails it by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= SEQ_IDLE;
         active_bank     <= '0;
         read_bank_index <= '0;
         read_address    <= '0;
         write_address   <= '0;
         op_done         <= 1'b0;
         op_done_id      <= '0;
         seq1_q          <= '0;
         seq2_q          <= '0;
         pass_q          <= '0;
         id_q            <= '0;
      end else begin
         write_address <= read_address;
         op_done       <= 1'b0;
         case (state)
            SEQ_IDLE, SEQ_DONE: begin
               if (load) begin
                  seq1_q       <= load_seq1;
                  seq2_q       <= load_seq2;
                  id_q         <= load_id;
                  active_bank  <= load_bank;
                  pass_q       <= '0;
                  read_address <= '0;
                  if (load_zero_c) begin
                     state           <= SEQ_DONE;
                     op_done         <= 1'b1;
                     op_done_id      <= load_id;
                     read_bank_index <= '0;
                  end else begin
                     state           <= SEQ_RUN;
                     read_bank_index <= load_bank;
                  end
               end else begin
                  state           <= SEQ_IDLE;
                  read_bank_index <= '0;
                  read_address    <= '0;
               end
            end
            SEQ_RUN: begin
               if (last_addr_c) begin
                  read_address <= '0;
                  if (last_pass_c) begin
                     state           <= SEQ_DONE;
                     op_done         <= 1'b1;
                     op_done_id      <= id_q;
                     read_bank_index <= '0;
                  end else begin
                     pass_q <= pass_q + SEQ2_W'(1);
                  end
               end else begin
                  read_address <= read_address + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state           <= SEQ_IDLE;
               read_bank_index <= '0;
               read_address    <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/psum_bank_manager.sv
// Psum bank allocator with one pending slot in front of the address sequencer.
module psum_bank_manager #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned OP_ID_WIDTH = 8,
   parameter int unsigned SMALL_DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   new_op_request,
   input  logic [ADDR_WIDTH-1:0]  seq1,
   input  logic [15:0]            seq2,
   input  logic [OP_ID_WIDTH-1:0] operation_id,
   output logic [2:0]             selected_bank,
   output logic                   assign_valid,
   output logic [2:0]             read_bank_index,
   output logic [ADDR_WIDTH-1:0]  read_address,
   output logic [ADDR_WIDTH-1:0]  write_address,
   output logic                   stall,
   output logic                   op_done,
   output logic [OP_ID_WIDTH-1:0] op_done_id
);

   import psum_pkg::*;

   logic [NUM_BANKS-1:0]   busy;
   op_desc_t               pending;
   logic                   pending_valid;
   seq_state_t             seq_state;
   bank_idx_t              active_bank;

   logic                   accept_c;
   logic                   big_c;
   bank_idx_t              chosen_c;
   logic                   seq_free_c;
   logic                   load_pending_c;
   logic                   load_new_c;
   logic                   seq_load_c;
   logic                   pending_valid_nxt_c;
   bank_idx_t              load_bank_c;
   logic [ADDR_WIDTH-1:0]  load_seq1_c;
   logic [15:0]            load_seq2_c;
   logic [OP_ID_WIDTH-1:0] load_id_c;

   assign accept_c   = new_op_request && !stall;
   assign big_c      = 32'(seq1) > 32'(SMALL_DEPTH);
   assign chosen_c   = pick_bank(busy, big_c);
   assign seq_free_c = (seq_state != SEQ_RUN);

   // A waiting op always takes the sequencer before a fresh request.
   assign load_pending_c = seq_free_c && pending_valid;
   assign load_new_c     = accept_c && seq_free_c && !pending_valid;
   assign seq_load_c     = load_pending_c || load_new_c;

   always_comb begin
      load_bank_c = chosen_c;
      load_seq1_c = seq1;
      load_seq2_c = seq2;
      load_id_c   = operation_id;
      if (load_pending_c) begin
         load_bank_c = pending.bank;
         load_seq1_c = ADDR_WIDTH'(pending.seq1);
         load_seq2_c = pending.seq2;
         load_id_c   = OP_ID_WIDTH'(pending.id);
      end
   end

   always_comb begin
      pending_valid_nxt_c = pending_valid;
      if (load_pending_c)
         pending_valid_nxt_c = 1'b0;
      if (accept_c && !load_new_c)
         pending_valid_nxt_c = 1'b1;
   end

   // A bank freed at this edge is still busy in chosen_c, so it cannot be reissued here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy          <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
         stall         <= 1'b0;
         selected_bank <= '0;
         assign_valid  <= 1'b0;
      end else begin
         assign_valid  <= accept_c;
         pending_valid <= pending_valid_nxt_c;
         stall         <= pending_valid_nxt_c;
         if (seq_state == SEQ_DONE)
            busy[active_bank] <= 1'b0;
         if (accept_c) begin
            busy[chosen_c] <= 1'b1;
            selected_bank  <= chosen_c;
            if (!load_new_c) begin
               pending.bank <= chosen_c;
               pending.seq1 <= DESC_ADDR_W'(seq1);
               pending.seq2 <= seq2;
               pending.id   <= DESC_ID_W'(operation_id);
            end
         end
      end
   end

   psum_addr_seq #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .OP_ID_WIDTH (OP_ID_WIDTH)
   ) u_addr_seq (
      .clk             (clk),
      .reset           (reset),
      .load            (seq_load_c),
      .load_bank       (load_bank_c),
      .load_seq1       (load_seq1_c),
      .load_seq2       (load_seq2_c),
      .load_id         (load_id_c),
      .state           (seq_state),
      .active_bank     (active_bank),
      .read_bank_index (read_bank_index),
      .read_address    (read_address),
      .write_address   (write_address),
      .op_done         (op_done),
      .op_done_id      (op_done_id)
   );

endmodule

// File: tb/tb_psum_bank_manager.sv
// Directed bench for psum_bank_manager: allocation, address streams, pending slot and zero-length ops.
module tb_psum_bank_manager;

   logic       clk;
   logic       reset;
   logic       new_op_request;
   logic [7:0] seq1;
   logic [15:0] seq2;
   logic [7:0] operation_id;
   logic [2:0] selected_bank;
   logic       assign_valid;
   logic [2:0] read_bank_index;
   logic [7:0] read_address;
   logic [7:0] write_address;
   logic       stall;
   logic       op_done;
   logic [7:0] op_done_id;

   int n_vec;
   int n_err;

   psum_bank_manager #(
      .ADDR_WIDTH  (8),
      .OP_ID_WIDTH (8),
      .SMALL_DEPTH (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .new_op_request  (new_op_request),
      .seq1            (seq1),
      .seq2            (seq2),
      .operation_id    (operation_id),
      .selected_bank   (selected_bank),
      .assign_valid    (assign_valid),
      .read_bank_index (read_bank_index),
      .read_address    (read_address),
      .write_address   (write_address),
      .stall           (stall),
      .op_done         (op_done),
      .op_done_id      (op_done_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; returns 1ns after the accept edge.
   task automatic issue(input logic [7:0] s1, input logic [15:0] s2, input logic [7:0] id);
      new_op_request = 1'b1;
      seq1           = s1;
      seq2           = s2;
      operation_id   = id;
      tick();
      new_op_request = 1'b0;
   endtask

   // Called in the first RUN cycle; walks the stream and checks the DONE cycle.
   task automatic run_stream(input int s1, input int s2, input logic [2:0] bank, input logic [7:0] id);
      for (int k = 0; k < s1 * s2; k++) begin
         check("rd_addr", 32'(read_address), 32'(k % s1));
         check("rd_bank", 32'(read_bank_index), 32'(bank));
         if (k > 0)
            check("wr_addr", 32'(write_address), 32'((k - 1) % s1));
         check("no_done", 32'(op_done), 32'd0);
         tick();
      end
      check("done", 32'(op_done), 32'd1);
      check("done_id", 32'(op_done_id), 32'(id));
      check("done_rd_addr", 32'(read_address), 32'd0);
      check("done_rd_bank", 32'(read_bank_index), 32'd0);
      check("done_wr_addr", 32'(write_address), 32'(s1 - 1));
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      reset          = 1'b1;
      new_op_request = 1'b0;
      seq1           = '0;
      seq2           = '0;
      operation_id   = '0;
      #20;
      reset = 1'b0;
      tick();

      check("rst_sel", 32'(selected_bank), 32'd0);
      check("rst_av", 32'(assign_valid), 32'd0);
      check("rst_rb", 32'(read_bank_index), 32'd0);
      check("rst_ra", 32'(read_address), 32'd0);
      check("rst_wa", 32'(write_address), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(op_done), 32'd0);
      check("rst_id", 32'(op_done_id), 32'd0);

      // Small op on bank 0
      issue(8'd8, 16'd3, 8'h01);
      check("t1_av", 32'(assign_valid), 32'd1);
      check("t1_sel", 32'(selected_bank), 32'd0);
      run_stream(8, 3, 3'd0, 8'h01);
      tick();
      check("t1_done_pulse", 32'(op_done), 32'd0);
      check("t1_av_pulse", 32'(assign_valid), 32'd0);
      check("t1_sel_hold", 32'(selected_bank), 32'd0);

      // Big op on bank 4
      issue(8'd20, 16'd2, 8'h02);
      check("t2_av", 32'(assign_valid), 32'd1);
      check("t2_sel", 32'(selected_bank), 32'd4);
      run_stream(20, 2, 3'd4, 8'h02);
      tick();

      // Active + pending, plus a request dropped while stalled
      issue(8'd8, 16'd2, 8'h03);
      check("t3_sel_a", 32'(selected_bank), 32'd0);
      check("t3_stall_a", 32'(stall), 32'd0);
      for (int k = 0; k < 16; k++) begin
         check("t3_rd_addr", 32'(read_address), 32'(k % 8));
         check("t3_done_lo", 32'(op_done), 32'd0);
         if (k == 3) begin
            new_op_request = 1'b1;
            seq1           = 8'd20;
            seq2           = 16'd2;
            operation_id   = 8'h04;
         end
         if (k == 4) begin
            check("t3_av_b", 32'(assign_valid), 32'd1);
            check("t3_sel_b", 32'(selected_bank), 32'd4);
            check("t3_stall_b", 32'(stall), 32'd1);
            seq1         = 8'd3;
            seq2         = 16'd1;
            operation_id = 8'h05;
         end
         if (k == 5 || k == 6) begin
            check("t3_drop_av", 32'(assign_valid), 32'd0);
            check("t3_drop_stall", 32'(stall), 32'd1);
         end
         if (k == 6)
            new_op_request = 1'b0;
         tick();
      end
      check("t3_done_a", 32'(op_done), 32'd1);
      check("t3_id_a", 32'(op_done_id), 32'h03);
      check("t3_stall_done", 32'(stall), 32'd1);
      tick();
      check("t3_stall_clr", 32'(stall), 32'd0);
      check("t3_sel_hold", 32'(selected_bank), 32'd4);
      run_stream(20, 2, 3'd4, 8'h04);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t3_no_ghost", 32'(op_done), 32'd0);
      end

      // Zero-length ops; bank 0 released at the same edge is not reused there
      issue(8'd5, 16'd0, 8'h06);
      check("t4_av", 32'(assign_valid), 32'd1);
      check("t4_sel", 32'(selected_bank), 32'd0);
      check("t4_done", 32'(op_done), 32'd1);
      check("t4_id", 32'(op_done_id), 32'h06);
      check("t4_rb", 32'(read_bank_index), 32'd0);
      issue(8'd0, 16'd4, 8'h07);
      check("t4_sel_b", 32'(selected_bank), 32'd1);
      check("t4_done_b", 32'(op_done), 32'd1);
      check("t4_id_b", 32'(op_done_id), 32'h07);
      tick();
      check("t4_idle", 32'(op_done), 32'd0);
      issue(8'd16, 16'd1, 8'h08);
      check("t5_sel", 32'(selected_bank), 32'd0);
      run_stream(16, 1, 3'd0, 8'h08);
      tick();
      check("t5_idle_done", 32'(op_done), 32'd0);
      check("t5_idle_stall", 32'(stall), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/psum_bank_manager.md
Name: psum_bank_manager

Overview:
- Allocates partial-sum (psum) buffer banks to incoming accumulation operations.
- Sequences each operation's read/accumulate/write address stream over its bank, then reports completion with the operation ID.
- Sits between the operation scheduler, which issues requests, and the psum SRAM banks, which consume the bank index and addresses.
- Supports one active operation plus one pending operation.

Parameters:
- ADDR_WIDTH, default 8: width of seq1 and of the bank addresses.
- OP_ID_WIDTH, default 8: width of the operation ID.
- SMALL_DEPTH, default 16: maximum seq1 that fits a small bank.
- Bank set is fixed at 8 banks: banks 0-3 are small (SMALL_DEPTH entries), banks 4-7 are big (2^ADDR_WIDTH entries).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- new_op_request  in  1  request strobe; sampled on each rising edge.
- seq1  in  ADDR_WIDTH  row length, i.e. addresses per pass.
- seq2  in  16  number of accumulation passes.
- operation_id  in  OP_ID_WIDTH  tag returned on completion.
- selected_bank  out  3  bank assigned to the accepted request.
- assign_valid  out  1  one-cycle pulse; selected_bank is valid while it is high.
- read_bank_index  out  3  bank of the active operation.
- read_address  out  ADDR_WIDTH  current read address.
- write_address  out  ADDR_WIDTH  accumulate write-back address.
- stall  out  1  high means requests are not accepted.
- op_done  out  1  one-cycle completion pulse.
- op_done_id  out  OP_ID_WIDTH  ID of the completed operation; valid with op_done.

Behaviour:
- Reset: all outputs are 0, all banks are free, the pending slot is empty, and the sequencer is IDLE.
- Acceptance: a request is accepted at a rising edge where new_op_request=1 and stall=0. A request made while stall=1 is dropped; the requester must hold or re-issue it.
- stall is registered and equals pending_valid. With at most 2 operations outstanding per class, a free bank always exists.
- Bank class: seq1 <= SMALL_DEPTH selects the small class, otherwise the big class. Within the class, the lowest-index free bank is chosen. Busy flags use pre-edge values, so a bank released at the same edge cannot be reused at that edge.
- Assignment: at the accept edge, selected_bank is set to the chosen bank and assign_valid is high for exactly the next cycle. selected_bank holds its value afterwards. The chosen bank is marked busy.
- If the sequencer is IDLE (or in DONE) and the pending slot is empty, the operation loads directly into the sequencer at the accept edge. Otherwise it is stored in the pending slot as {bank, seq1, seq2, id}.
- Sequencer states are IDLE, RUN and DONE.
- RUN: one address per cycle, with a = 0..seq1-1 inner and p = 0..seq2-1 outer.
  - read_address = a; read_bank_index = active bank.
  - Total RUN length is seq1*seq2 cycles; a wraps to 0 at each pass boundary.
- write_address is read_address registered every cycle, i.e. one-cycle lag for the read-add-write pipeline.
- Outside RUN, read_address = 0 and read_bank_index = 0.
- DONE lasts one cycle:
  - op_done = 1 and op_done_id = the active ID.
  - The active bank is freed at the DONE->next edge.
  - If an operation is pending, it loads at that edge and enters RUN, and the pending slot clears; otherwise the sequencer goes to IDLE.
- Zero-length operations (seq1 == 0 or seq2 == 0): the bank is still assigned, RUN is skipped, and DONE occurs in the cycle after load.
- Simultaneous accept and DONE edge: the pending operation (if any) loads first; the new request goes to the pending slot.
- Reset mid-operation aborts everything immediately, with no op_done.

Decomposition:
- psum_pkg holds:
  - NUM_BANKS = 8, NUM_SMALL = 4, SMALL_DEPTH;
  - a bank index typedef;
  - an op descriptor struct {bank, seq1, seq2, id};
  - the sequencer state enum.
- One sub-module: psum_addr_seq, the nested a/p counter with DONE generation. Allocation and the pending slot live in the top level.

Test Plan:
- Reset held for 20 ns, then released -> all outputs 0, stall=0.
- Request seq1=8, seq2=3, id=0x01 -> assign_valid pulse with selected_bank=0. There are 24 RUN cycles with read_address cycling 0..7 three times and write_address lagging by 1. Then op_done=1 with op_done_id=0x01.
- Request seq1=20, seq2=2, id=0x02 -> selected_bank=4 (big class), 40 RUN cycles with addresses 0..19 twice, then op_done with id 0x02.
- Request id=0x03 (seq1=8, seq2=2), then id=0x04 (seq1=20, seq2=2) 4 cycles later:
  - 0x03 gets bank 0; 0x04 gets bank 4 and goes pending, so stall=1.
  - op_done id=0x03 occurs after 16 RUN cycles.
  - 0x04 starts at the next edge, stall drops, and op_done id=0x04 follows after 40 RUN cycles.
- Third request while stall=1 -> ignored: no assign_valid, no op_done for it.
- Request with seq2=0 -> assign_valid, then op_done in the cycle after load, with no RUN cycles; the bank is freed.
